// File: rtl/usb_fs_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_fs_line_ctrl
// Purpose  : Full-speed USB line controller. Sits between the D+/D- pads and
//            the serial engine. A single line-state machine handles detach
//            (SE0 drive), host bus-reset detection, idle-J suspend detection,
//            host resume and device remote-wakeup K signalling. All line
//            sensing goes through a 2-flop synchroniser.
//
// Ports    : clk            system clock (48 MHz nominal)
//            reset_n        asynchronous active-low reset
//            dp, dn         raw USB lines (bidirectional)
//            oe             serial engine transmit enable
//            dp_tx, dn_tx   transmit values, used when oe=1
//            dp_rx, dn_rx   received line values to the serial engine
//            detach_req     level, hold the device detached
//            resume_req     request remote wakeup while suspended
//            usb_reset      bus reset in progress
//            suspend        bus suspended
//            resume_active  K being driven for remote wakeup
//            connected      state is not DETACH
//            line_state     synchronised {dp,dn}
//
// Revision : 1.0 - initial release
// ============================================================================
module usb_fs_line_ctrl #(
    parameter int CONNECT_SE0_CYCLES = 12000,
    parameter int BUS_RESET_CYCLES   = 30000,
    parameter int SUSPEND_CYCLES     = 144000,
    parameter int RESUME_CYCLES      = 96000,
    parameter int TIMER_W            = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire        dp,
    inout  wire        dn,
    input  logic       oe,
    input  logic       dp_tx,
    input  logic       dn_tx,
    output logic       dp_rx,
    output logic       dn_rx,
    input  logic       detach_req,
    input  logic       resume_req,
    output logic       usb_reset,
    output logic       suspend,
    output logic       resume_active,
    output logic       connected,
    output logic [1:0] line_state
);

    // Line codes as {dp,dn}
    localparam logic [1:0] c_LS_SE0 = 2'b00;
    localparam logic [1:0] c_LS_J   = 2'b10;

    // Each timed condition fires when the timer holds N-1 and the qualifying
    // sample is present, i.e. on the N-th consecutive qualifying edge.
    localparam logic [TIMER_W-1:0] c_CONNECT_LAST   = TIMER_W'(CONNECT_SE0_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_BUS_RESET_LAST = TIMER_W'(BUS_RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_SUSPEND_LAST   = TIMER_W'(SUSPEND_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_RESUME_LAST    = TIMER_W'(RESUME_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_TIMER_MAX      = {TIMER_W{1'b1}};

    typedef enum logic [2:0] {
        ST_DETACH  = 3'd0,
        ST_ACTIVE  = 3'd1,
        ST_RESET   = 3'd2,
        ST_SUSPEND = 3'd3,
        ST_RESUME  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic                 w_qual;

    logic [1:0]           r_sync1;
    logic [1:0]           r_line;

    logic                 w_ls_se0;
    logic                 w_ls_j;
    logic                 w_ls_pending;

    logic                 w_drive_en;
    logic                 w_dp_out;
    logic                 w_dn_out;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser on the raw pad values
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b00;
            r_line  <= 2'b00;
        end else begin
            r_sync1 <= {dp, dn};
            r_line  <= r_sync1;
        end
    end

    assign line_state = r_line;

    assign w_ls_se0 = (r_line == c_LS_SE0);
    assign w_ls_j   = (r_line == c_LS_J);
    // A different code is already in the first stage: line_state changes at
    // this edge, so the running count for the current code is finished.
    assign w_ls_pending = (r_sync1 != r_line);

    // ------------------------------------------------------------------------
    // Next-state logic and shared timer qualification
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_qual      = 1'b0;

        if (detach_req) begin
            // Detach wins over every other transition, from any state.
            w_state_nxt = ST_DETACH;
        end else begin
            case (r_state)
                ST_DETACH: begin
                    w_qual = 1'b1;
                    if (r_timer == c_CONNECT_LAST) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    // One timer serves both the SE0 and the J run; clearing on
                    // a code change keeps it tied to whichever code is present.
                    w_qual = !oe && (w_ls_se0 || w_ls_j) && !w_ls_pending;
                    if (!oe && w_ls_se0 && (r_timer == c_BUS_RESET_LAST)) begin
                        w_state_nxt = ST_RESET;
                    end else if (!oe && w_ls_j && (r_timer == c_SUSPEND_LAST)) begin
                        w_state_nxt = ST_SUSPEND;
                    end
                end

                ST_RESET: begin
                    w_qual = w_ls_se0;
                    if (!w_ls_se0) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end

                ST_SUSPEND: begin
                    // Host line activity takes precedence over a local wakeup.
                    w_qual = w_ls_j;
                    if (!w_ls_j) begin
                        w_state_nxt = ST_ACTIVE;
                    end else if (resume_req) begin
                        w_state_nxt = ST_RESUME;
                    end
                end

                ST_RESUME: begin
                    w_qual = 1'b1;
                    if (r_timer == c_RESUME_LAST) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end

                default: begin
                    w_state_nxt = ST_DETACH;
                end
            endcase
        end
    end

    // Saturating timer: cleared on any transition or unqualified sample.
    always_comb begin
        w_timer_nxt = r_timer;
        if ((w_state_nxt != r_state) || !w_qual) begin
            w_timer_nxt = '0;
        end else if (r_timer != c_TIMER_MAX) begin
            w_timer_nxt = r_timer + TIMER_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State, timer and registered status outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_DETACH;
            r_timer       <= '0;
            usb_reset     <= 1'b0;
            suspend       <= 1'b0;
            resume_active <= 1'b0;
            connected     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            usb_reset     <= (w_state_nxt == ST_RESET);
            suspend       <= (w_state_nxt == ST_SUSPEND);
            resume_active <= (w_state_nxt == ST_RESUME);
            connected     <= (w_state_nxt != ST_DETACH);
        end
    end

    // ------------------------------------------------------------------------
    // Pad drive: detach SE0 > remote-wakeup K > serial engine > released
    // ------------------------------------------------------------------------
    always_comb begin
        w_drive_en = 1'b0;
        w_dp_out   = 1'b0;
        w_dn_out   = 1'b0;
        if (r_state == ST_DETACH) begin
            w_drive_en = 1'b1;
        end else if (r_state == ST_RESUME) begin
            w_drive_en = 1'b1;
            w_dn_out   = 1'b1;
        end else if (oe) begin
            w_drive_en = 1'b1;
            w_dp_out   = dp_tx;
            w_dn_out   = dn_tx;
        end
    end

    assign dp = w_drive_en ? w_dp_out : 1'bz;
    assign dn = w_drive_en ? w_dn_out : 1'bz;

    // While we own the bus the serial engine sees a quiet idle J rather
    // than an echo of our own drive.
    always_comb begin
        dp_rx = r_line[1];
        dn_rx = r_line[0];
        if (oe || (r_state == ST_DETACH) || (r_state == ST_RESUME)) begin
            dp_rx = 1'b1;
            dn_rx = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_fs_line_ctrl
// Purpose  : Self-checking bench for usb_fs_line_ctrl. A behavioural model
//            tracks sample counts per line condition and predicts every
//            output each cycle; directed phases pin key latencies with
//            literal values; a randomized phase exercises the state space.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_fs_line_ctrl;

    localparam int CONNECT = 8;
    localparam int BUS     = 20;
    localparam int SUS     = 40;
    localparam int RSM     = 10;
    localparam int TW      = 18;

    localparam int M_DET = 0;
    localparam int M_ACT = 1;
    localparam int M_RST = 2;
    localparam int M_SUS = 3;
    localparam int M_RSM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, oe, dp_tx, dn_tx, detach_req, resume_req;
    logic       host_dp, host_dn;
    wire        dp, dn;
    logic       dp_rx, dn_rx, usb_reset, suspend, resume_active, connected;
    logic [1:0] line_state;

    int n_checks = 0;
    int n_pass   = 0;

    usb_fs_line_ctrl #(
        .CONNECT_SE0_CYCLES (CONNECT),
        .BUS_RESET_CYCLES   (BUS),
        .SUSPEND_CYCLES     (SUS),
        .RESUME_CYCLES      (RSM),
        .TIMER_W            (TW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dp            (dp),
        .dn            (dn),
        .oe            (oe),
        .dp_tx         (dp_tx),
        .dn_tx         (dn_tx),
        .dp_rx         (dp_rx),
        .dn_rx         (dn_rx),
        .detach_req    (detach_req),
        .resume_req    (resume_req),
        .usb_reset     (usb_reset),
        .suspend       (suspend),
        .resume_active (resume_active),
        .connected     (connected),
        .line_state    (line_state)
    );

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int         m_st, m_rel, m_run, m_left;
    logic [1:0] m_code, m_s1, m_ls;
    logic       m_usb_reset, m_suspend, m_resume_active, m_connected;

    int         n_st, n_rel, n_run, n_left;
    logic [1:0] n_code;

    logic       m_drive;
    logic [1:0] m_pad, m_bus, m_rx;

    always_comb begin
        m_drive = (m_st == M_DET) || (m_st == M_RSM) || oe;
        if (m_st == M_DET)      m_pad = 2'b00;
        else if (m_st == M_RSM) m_pad = 2'b01;
        else                    m_pad = {dp_tx, dn_tx};
        m_bus = m_drive ? m_pad : {host_dp, host_dn};
        m_rx  = (oe || m_st == M_DET || m_st == M_RSM) ? 2'b10 : m_ls;
    end

    // The host holds the line whenever the device is expected to release it.
    assign dp = m_drive ? 1'bz : host_dp;
    assign dn = m_drive ? 1'bz : host_dn;

    always_comb begin
        n_st   = m_st;
        n_rel  = m_rel;
        n_run  = m_run;
        n_code = m_code;
        n_left = m_left;
        if (detach_req) begin
            n_st  = M_DET;
            n_rel = 0;
        end else begin
            case (m_st)
                M_DET: begin
                    n_rel = m_rel + 1;
                    if (n_rel == CONNECT) begin
                        n_st  = M_ACT;
                        n_run = 0;
                    end
                end
                M_ACT: begin
                    // run = number of consecutive idle samples of one code
                    if (oe || !(m_ls == 2'b00 || m_ls == 2'b10)) begin
                        n_run = 0;
                    end else if (m_run > 0 && m_ls == m_code) begin
                        n_run = m_run + 1;
                    end else begin
                        n_run  = 1;
                        n_code = m_ls;
                    end
                    if (m_ls == 2'b00 && n_run == BUS)      n_st = M_RST;
                    else if (m_ls == 2'b10 && n_run == SUS) n_st = M_SUS;
                end
                M_RST: begin
                    if (m_ls != 2'b00) begin
                        n_st  = M_ACT;
                        n_run = 0;
                    end
                end
                M_SUS: begin
                    if (m_ls != 2'b10) begin
                        n_st  = M_ACT;
                        n_run = 0;
                    end else if (resume_req) begin
                        n_st   = M_RSM;
                        n_left = RSM;
                    end
                end
                M_RSM: begin
                    n_left = m_left - 1;
                    if (n_left == 0) begin
                        n_st  = M_ACT;
                        n_run = 0;
                    end
                end
                default: n_st = M_DET;
            endcase
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st            <= M_DET;
            m_rel           <= 0;
            m_run           <= 0;
            m_left          <= 0;
            m_code          <= 2'b00;
            m_s1            <= 2'b00;
            m_ls            <= 2'b00;
            m_usb_reset     <= 1'b0;
            m_suspend       <= 1'b0;
            m_resume_active <= 1'b0;
            m_connected     <= 1'b0;
        end else begin
            m_st            <= n_st;
            m_rel           <= n_rel;
            m_run           <= n_run;
            m_left          <= n_left;
            m_code          <= n_code;
            m_s1            <= m_bus;
            m_ls            <= m_s1;
            m_usb_reset     <= (n_st == M_RST);
            m_suspend       <= (n_st == M_SUS);
            m_resume_active <= (n_st == M_RSM);
            m_connected     <= (n_st != M_DET);
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("cycle",
              int'({dp, dn, dp_rx, dn_rx, usb_reset, suspend, resume_active,
                    connected, line_state}),
              int'({m_bus, m_rx, m_usb_reset, m_suspend, m_resume_active,
                    m_connected, m_ls}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n, k, hits;
        reset_n = 1'b1; oe = 1'b0; dp_tx = 1'b0; dn_tx = 1'b0;
        detach_req = 1'b0; resume_req = 1'b0; host_dp = 1'b1; host_dn = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_pads", int'({dp, dn, dp_rx, dn_rx}), 4'b0010);
        check("rst_status", int'({usb_reset, suspend, resume_active, connected, line_state}), 0);

        // Power-up connect
        reset_n = 1'b1;
        n = 0;
        while (!connected && n < 50) begin tick(); n++; end
        check("connect_delay", n, CONNECT);
        check("model_connect", int'(m_connected), 1);
        tick(); tick();
        check("connect_idle", int'({dp, dn, dp_rx, dn_rx, line_state}), 6'b101010);

        // Bus reset: 30 cycles of SE0
        host_dp = 1'b0; host_dn = 1'b0;
        n = 0;
        while (line_state != 2'b00 && n < 10) begin tick(); n++; end
        k = 0;
        while (!usb_reset && k < 50) begin tick(); k++; end
        check("bus_reset_rise", k, BUS);
        repeat (30 - 2 - BUS) tick();
        host_dp = 1'b1;
        n = 0;
        while (line_state == 2'b00 && n < 10) begin tick(); n++; end
        check("reset_hold", int'(usb_reset), 1);
        tick();
        check("reset_fall", int'(usb_reset), 0);

        // 19-cycle SE0 must not reset
        repeat (3) tick();
        host_dp = 1'b0; hits = 0;
        for (int i = 0; i < 19; i++) begin tick(); if (usb_reset) hits++; end
        host_dp = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (usb_reset) hits++; end
        check("short_se0", hits, 0);

        // Suspend after 40 idle J samples
        host_dp = 1'b0; host_dn = 1'b1;
        repeat (3) tick();
        host_dp = 1'b1; host_dn = 1'b0;
        n = 0;
        while (line_state != 2'b10 && n < 10) begin tick(); n++; end
        k = 0;
        while (!suspend && k < 100) begin tick(); k++; end
        check("suspend_rise", k, SUS);
        check("model_suspend", int'(m_suspend), 1);

        // Host resume with K
        host_dp = 1'b0; host_dn = 1'b1;
        n = 0;
        while (line_state != 2'b01 && n < 10) begin tick(); n++; end
        check("susp_hold", int'(suspend), 1);
        tick();
        check("susp_fall", int'({suspend, usb_reset, resume_active, connected}), 4'b0001);
        check("active_rx", int'({dp_rx, dn_rx}), 2'b01);
        host_dp = 1'b1; host_dn = 1'b0;

        // Remote wakeup
        n = 0;
        while (!suspend && n < 100) begin tick(); n++; end
        check("wake_suspended", int'(suspend), 1);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        check("rsm_start", int'({resume_active, suspend, dp, dn, dp_rx, dn_rx}), 6'b100110);
        k = 0;
        while (resume_active && k < 50) begin k++; tick(); end
        check("rsm_len", k, RSM);
        check("rsm_done", int'({dp, dn, connected, suspend}), 4'b1010);
        resume_req = 1'b1;
        tick(); tick();
        resume_req = 1'b0;
        check("rsm_ignored", int'(resume_active), 0);

        // Transmit activity keeps the bus out of suspend
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 30 == 0) oe = ~oe;
            dp_tx = 1'($urandom_range(0, 1));
            dn_tx = 1'($urandom_range(0, 1));
            tick();
            if (suspend) hits++;
        end
        check("oe_no_suspend", hits, 0);

        // Detach mid-transmit
        oe = 1'b1; dp_tx = 1'b1; dn_tx = 1'b0;
        tick();
        check("tx_drive", int'({dp, dn}), 2'b10);
        detach_req = 1'b1;
        tick();
        check("detach_se0", int'({dp, dn, connected}), 3'b000);
        repeat (3) tick();
        detach_req = 1'b0;
        n = 0;
        while (!connected && n < 50) begin tick(); n++; end
        check("reconnect", n, CONNECT);
        oe = 1'b0;

        // Randomized traffic
        for (int seg = 0; seg < 150; seg++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 19);
            len = $urandom_range(1, 60);
            if (sel < 10)      {host_dp, host_dn} = 2'b10;
            else if (sel < 15) {host_dp, host_dn} = 2'b00;
            else if (sel < 18) {host_dp, host_dn} = 2'b01;
            else               {host_dp, host_dn} = 2'b11;
            for (int c = 0; c < len; c++) begin
                if (oe) oe = ($urandom_range(0, 9) != 0);
                else    oe = ($urandom_range(0, 99) == 0);
                dp_tx      = 1'($urandom_range(0, 1));
                dn_tx      = 1'($urandom_range(0, 1));
                resume_req = ($urandom_range(0, 29) == 0);
                detach_req = ($urandom_range(0, 499) == 0);
                tick();
            end
        end

        // Asynchronous reset in the middle of remote wakeup
        detach_req = 1'b0; oe = 1'b0; resume_req = 1'b0;
        host_dp = 1'b1; host_dn = 1'b0;
        n = 0;
        while (!suspend && n < 300) begin tick(); n++; end
        check("pre_rsm_susp", int'(suspend), 1);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        tick(); tick();
        check("rsm_active2", int'(resume_active), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_pads", int'({dp, dn, dp_rx, dn_rx}), 4'b0010);
        check("async_status", int'({usb_reset, suspend, resume_active, connected}), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        n = 0;
        while (!connected && n < 50) begin tick(); n++; end
        check("post_reset_connect", n, CONNECT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_fs_line_ctrl.md
# usb_fs_line_ctrl

Full-speed USB line controller sitting between the D+/D- pads and the USB serial engine. It generalises the pad mux with cycle-count parameters and a single line-state machine. The machine handles power-on and software-requested detach (SE0 drive), host bus-reset detection, idle-J suspend detection, host resume, and device remote-wakeup K signalling. All line sensing goes through a 2-flop synchroniser.

## Interface
Parameters:
- CONNECT_SE0_CYCLES, 12000: cycles SE0 is driven after reset or detach release.
- BUS_RESET_CYCLES, 30000: consecutive received SE0 samples that declare a bus reset.
- SUSPEND_CYCLES, 144000: consecutive received J samples that declare suspend (3 ms at 48 MHz).
- RESUME_CYCLES, 96000: cycles K is driven for remote wakeup.
- TIMER_W, 18: timer width. Every *_CYCLES value must be ≥ 2 and < 2^TIMER_W.

Ports:
- clk  in  1  system clock (48 MHz nominal)
- reset_n  in  1  asynchronous, active-low reset
- dp, dn  inout  1 each  raw USB lines
- oe  in  1  serial engine transmit enable
- dp_tx, dn_tx  in  1 each  transmit values, used when oe=1
- dp_rx, dn_rx  out  1 each  received line values to the serial engine
- detach_req  in  1  level; hold the device detached (SE0 driven)
- resume_req  in  1  pulse/level; request remote wakeup while suspended
- usb_reset  out  1  level; bus reset in progress
- suspend  out  1  level; bus suspended
- resume_active  out  1  level; K being driven
- connected  out  1  level; state is not DETACH
- line_state  out  2  synchronised {dp,dn}

## Operation
- Synchroniser: two flops per line, reset to 0; line_state = second stage.
- Line codes: J = 10, K = 01, SE0 = 00, SE1 = 11.
- Timer: a single saturating TIMER_W counter. It is cleared on every state transition and whenever the current state's qualifying condition is false; otherwise it increments.
- States:
  - DETACH:
    - Drive dp=dn=0.
    - Qualifying condition is "detach_req=0". When timer = CONNECT_SE0_CYCLES-1 and the condition holds → ACTIVE.
    - detach_req=1 from any state → DETACH at the next edge; this has priority over every other transition.
  - ACTIVE:
    - Two timing conditions run in the same timer. "oe=0 and line_state=SE0" toward BUS_RESET_CYCLES; "oe=0 and line_state=J" toward SUSPEND_CYCLES.
    - The timer clears whenever line_state changes code or oe=1.
    - SE0 count reached → RESET. J count reached → SUSPEND.
  - RESET: usb_reset=1. The first sample with line_state≠SE0 → ACTIVE.
  - SUSPEND: suspend=1.
    - line_state≠J → ACTIVE. This is a host resume or reset; the SE0 count then restarts from 0.
    - Else resume_req=1 → RESUME.
    - If both occur in the same cycle, the line change wins.
  - RESUME: drive dp=0, dn=1; resume_active=1. When timer = RESUME_CYCLES-1 → ACTIVE. resume_req is ignored in every other state.
- Pad drive priority: DETACH SE0 > RESUME K > oe ? {dp_tx,dn_tx} > Z.
- Receive outputs:
  - When oe=1 or state ∈ {DETACH, RESUME}: dp_rx=1, dn_rx=0 (forced J).
  - Otherwise: dp_rx/dn_rx = line_state.
- Mid-operation reset: reset_n low asserts immediately, regardless of state. The pads go to SE0 and the block restarts the detach count.

## Timing
- Reset values while reset_n=0: state DETACH, timer 0, usb_reset=0, suspend=0, resume_active=0, connected=0, line_state=00, dp=dn=0 driven, dp_rx=1, dn_rx=0.
- Synchroniser latency: a pad change appears on line_state 2 edges later.
- Detach release: connected rises at edge CONNECT_SE0_CYCLES after the first edge at which reset_n=1 and detach_req=0; the pads go to Z/oe-drive in the same cycle.
- Bus reset: usb_reset rises BUS_RESET_CYCLES edges after the first SE0 sample on line_state. It falls 1 edge after line_state leaves SE0.
- Suspend: suspend rises SUSPEND_CYCLES edges after the first J sample. It falls 1 edge after a non-J sample.
- Remote wakeup: resume_active and K drive start 1 edge after resume_req is sampled high in SUSPEND. suspend falls on that same edge. K lasts exactly RESUME_CYCLES cycles.
- Status outputs are registered. dp/dn/dp_rx/dn_rx are combinational from the state register and oe.

## Test plan
Use CONNECT=8, BUS_RESET=20, SUSPEND=40, RESUME=10.
- Power-up: release reset_n with host pulling J → SE0 driven for exactly 8 cycles, then connected=1, dp/dn=Z, dp_rx/dn_rx=10.
- Bus reset: host drives SE0 for 30 cycles → usb_reset high from cycle 20 after line_state=00 until 1 cycle after J returns; a 19-cycle SE0 gives no reset.
- Suspend/host resume: idle J for 40 cycles → suspend=1; host drives K → suspend=0 one cycle after line_state=01; state is ACTIVE.
- Remote wakeup: in SUSPEND pulse resume_req for 1 cycle → dp=0, dn=1 for 10 cycles, resume_active=1, dp_rx/dn_rx=10; afterwards ACTIVE with pads Z. resume_req in ACTIVE has no effect.
- oe activity: toggle oe every 30 cycles with J on the bus → suspend never asserts. Assert detach_req mid-transmit → SE0 on the next edge overriding dp_tx/dn_tx; release → 8-cycle SE0 then reconnect.
- Async reset mid-RESUME: drop reset_n → pads SE0 and all status outputs 0 immediately, without waiting for a clock edge.
